// File: rtl/fpsr_pkg.sv
// Shared constants for the fpsr board I/O front end: segment decode table,
// blank pattern and default cycle counts for a 100 MHz board clock.
package fpsr_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int DEB_10MS  = 1_000_000;
    localparam int TICK_5S   = 500_000_000;
    localparam int SCAN_1KHZ = 100_000;

    // Active-low {Ca..Cg}; listed from F down to 0 so HEX_SEG[n] is digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/fpsr_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a single-cycle pulse on each accepted rising edge.
module fpsr_debounce
    import fpsr_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_10MS
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            btn_pulse <= 1'b0;
            // Any return to the accepted level restarts the stability count.
            if (sync_p1 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                btn_level <= sync_p1;
                btn_pulse <= sync_p1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fpsr_io_ctrl.sv
// Board I/O front end for the fpsr game: debounced buttons, pausable game
// tick timer and a registered multiplexed seven-segment scanner.
module fpsr_io_ctrl
    import fpsr_pkg::*;
#(
    parameter int NUM_BTN     = 5,
    parameter int DEB_CYCLES  = DEB_10MS,
    parameter int TICK_CYCLES = TICK_5S,
    parameter int TICK_W      = 8,
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_CYCLES = SCAN_1KHZ
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_BTN-1:0]      btn_raw,
    output logic [NUM_BTN-1:0]      btn_level,
    output logic [NUM_BTN-1:0]      btn_pulse,
    input  logic                    tick_en,
    input  logic                    tick_clr,
    output logic                    tick,
    output logic [TICK_W-1:0]       tick_cnt,
    input  logic [4*NUM_DIGITS-1:0] ssd_data,
    input  logic [NUM_DIGITS-1:0]   ssd_dp,
    input  logic [NUM_DIGITS-1:0]   ssd_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        fpsr_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .Clk      (Clk),
            .Reset    (Reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

    logic [PW-1:0] pre;

    // Prescaler holds while tick_en is low, so a pause loses no elapsed time.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre      <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
        end else if (tick_clr) begin
            pre      <= '0;
            tick     <= 1'b0;
            tick_cnt <= '0;
        end else if (tick_en) begin
            if (pre == PRE_LAST) begin
                pre      <= '0;
                tick     <= 1'b1;
                tick_cnt <= tick_cnt + TICK_W'(1);
            end else begin
                pre  <= pre + PW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    logic [SW-1:0]         scan_cnt;
    logic [DW-1:0]         dig;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        nib     = ssd_data[{dig, 2'b00} +: 4];
        if (!ssd_blank[dig]) begin
            an_nxt[dig] = 1'b0;
            seg_nxt     = hex_to_seg(nib);
            dp_nxt      = ~ssd_dp[dig];
        end
    end

    // Anode and cathodes share one register stage so they switch together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
            dig      <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig      <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpsr_io_ctrl.sv
// Scoreboard bench for fpsr_io_ctrl with small cycle parameters; expected
// outputs are queued against a cycle number when stimulus is applied.
module tb_fpsr_io_ctrl;

    localparam int NB = 5;
    localparam int ND = 4;
    localparam int SEL_LVL  = 0;
    localparam int SEL_PUL  = 1;
    localparam int SEL_TICK = 2;
    localparam int SEL_TCNT = 3;
    localparam int SEL_SSD  = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [NB-1:0]   btn_raw;
    logic [NB-1:0]   btn_level;
    logic [NB-1:0]   btn_pulse;
    logic            tick_en;
    logic            tick_clr;
    logic            tick;
    logic [1:0]      tick_cnt;
    logic [4*ND-1:0] ssd_data;
    logic [ND-1:0]   ssd_dp;
    logic [ND-1:0]   ssd_blank;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;

    fpsr_io_ctrl #(
        .NUM_BTN(NB), .DEB_CYCLES(4), .TICK_CYCLES(5), .TICK_W(2),
        .NUM_DIGITS(ND), .SCAN_CYCLES(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_pulse(btn_pulse), .tick_en(tick_en), .tick_clr(tick_clr),
        .tick(tick), .tick_cnt(tick_cnt), .ssd_data(ssd_data), .ssd_dp(ssd_dp),
        .ssd_blank(ssd_blank), .an(an), .seg(seg), .dp(dp)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_LVL:  return 32'(btn_level);
            SEL_PUL:  return 32'(btn_pulse);
            SEL_TICK: return 32'(tick);
            SEL_TCNT: return 32'(tick_cnt);
            default:  return 32'({an, seg, dp});
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            SEL_LVL:  return "btn_level";
            SEL_PUL:  return "btn_pulse";
            SEL_TICK: return "tick";
            SEL_TCNT: return "tick_cnt";
            default:  return "an_seg_dp";
        endcase
    endfunction

    function automatic logic [31:0] ssd_exp(input int step);
        case (step)
            0:       return 32'({4'b1110, 7'b0000000, 1'b0});
            1:       return 32'({4'b1101, 7'b0000001, 1'b1});
            2:       return 32'({4'b1111, 7'b1111111, 1'b1});
            default: return 32'({4'b0111, 7'b1001111, 1'b1});
        endcase
    endfunction

    task automatic push(input int d, input int sel, input logic [31:0] v);
        sb_t e;
        e.cyc = cyc + d;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_level"}, 32'(btn_level), 32'h0);
        chk({pfx, "_pulse"}, 32'(btn_pulse), 32'h0);
        chk({pfx, "_tick"}, 32'(tick), 32'h0);
        chk({pfx, "_tcnt"}, 32'(tick_cnt), 32'h0);
        chk({pfx, "_ssd"}, 32'({an, seg, dp}), 32'hFFF);
    endtask

    always @(posedge Clk) begin
        #2;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                chk(sel_name(sb_q[i].sel), observe(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        Reset     = 1'b1;
        btn_raw   = '0;
        tick_en   = 1'b0;
        tick_clr  = 1'b0;
        ssd_data  = 16'h1208;
        ssd_blank = 4'b0100;
        ssd_dp    = 4'b0001;
        #1;
        Reset = 1'b0;
        step(3);
        chk_reset_vals("rst");
        Reset = 1'b1;
        step(2);

        // Clean press on channel 0
        btn_raw[0] = 1'b1;
        push(5, SEL_LVL, 0);  push(5, SEL_PUL, 0);
        push(6, SEL_LVL, 1);  push(6, SEL_PUL, 1);
        push(7, SEL_LVL, 1);  push(7, SEL_PUL, 0);
        step(10);

        // Short glitch on channel 1 is rejected
        btn_raw[1] = 1'b1;
        for (int d = 1; d <= 10; d++) begin
            push(d, SEL_LVL, 32'h1);
            push(d, SEL_PUL, 32'h0);
        end
        step(3);
        btn_raw[1] = 1'b0;
        step(9);

        // Release of channel 0: level drops, no pulse
        btn_raw[0] = 1'b0;
        push(5, SEL_LVL, 1);
        push(6, SEL_LVL, 0);
        for (int d = 5; d <= 8; d++) push(d, SEL_PUL, 0);
        step(10);

        // Tick timer: run 12 cycles, pause 7, resume
        tick_clr = 1'b1;
        step(1);
        tick_clr = 1'b0;
        tick_en  = 1'b1;
        for (int d = 1; d <= 12; d++) begin
            push(d, SEL_TICK, (d == 5 || d == 10) ? 32'h1 : 32'h0);
            push(d, SEL_TCNT, (d >= 10) ? 32'h2 : ((d >= 5) ? 32'h1 : 32'h0));
        end
        step(12);
        tick_en = 1'b0;
        for (int d = 1; d <= 7; d++) begin
            push(d, SEL_TICK, 0);
            push(d, SEL_TCNT, 2);
        end
        step(7);
        tick_en = 1'b1;
        push(1, SEL_TICK, 0);  push(2, SEL_TICK, 0);
        push(3, SEL_TICK, 1);  push(3, SEL_TCNT, 3);
        push(7, SEL_TICK, 0);
        push(8, SEL_TICK, 1);  push(8, SEL_TCNT, 0);
        step(12);

        // Clear on the terminal-count cycle suppresses the tick
        tick_clr = 1'b1;
        push(1, SEL_TICK, 0);
        push(1, SEL_TCNT, 0);
        step(1);
        tick_clr = 1'b0;
        push(4, SEL_TICK, 0);
        push(5, SEL_TICK, 1);
        push(5, SEL_TCNT, 1);
        step(5);
        tick_en = 1'b0;

        // Asynchronous reset mid-debounce and mid-scan
        ssd_blank  = 4'b0000;
        btn_raw[2] = 1'b1;
        step(3);
        Reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        ssd_blank = 4'b0100;
        step(2);
        Reset = 1'b1;
        chk("rel_ssd", 32'({an, seg, dp}), 32'hFFF);
        push(5, SEL_LVL, 32'h0);
        push(6, SEL_LVL, 32'h4);
        push(6, SEL_PUL, 32'h4);
        push(7, SEL_PUL, 32'h0);
        for (int d = 1; d <= 24; d++) push(d, SEL_SSD, ssd_exp(((d - 1) / 3) % 4));
        step(26);

        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpsr_io_ctrl.md
Name: fpsr_io_ctrl

Overview:
Parametrised board-I/O front end for the fpsr game top level. It has three functions:
- Per-button synchronise, debounce and one-shot pulse generation.
- An exact-period, pausable game tick timer with a tick counter, which replaces the free-running divided-clock timer.
- A multiplexed N-digit seven-segment scanner with hex decode, per-digit blanking and decimal points.

It sits between the board pins and the game FSM. All logic runs on one clock; there are no derived clocks.

Parameters:
NUM_BTN, 5, number of button channels
DEB_CYCLES, 1000000, stable cycles required to accept a button level change (10 ms at 100 MHz); must be >= 2
TICK_CYCLES, 500000000, enabled cycles per tick (5 s at 100 MHz); must be >= 2
TICK_W, 8, width of the tick counter
NUM_DIGITS, 8, seven-segment digits scanned; range 1..8
SCAN_CYCLES, 100000, cycles each digit is lit; must be >= 1

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
btn_raw  in  NUM_BTN  raw, asynchronous button inputs
btn_level  out  NUM_BTN  debounced button level
btn_pulse  out  NUM_BTN  one-cycle pulse on each debounced rising edge
tick_en  in  1  tick timer runs while 1
tick_clr  in  1  synchronous clear of the timer
tick  out  1  one-cycle pulse every TICK_CYCLES enabled cycles
tick_cnt  out  TICK_W  ticks since clear, modulo 2^TICK_W
ssd_data  in  4*NUM_DIGITS  hex nibble per digit; digit k is [4k+3:4k]
ssd_dp  in  NUM_DIGITS  1 = decimal point lit for that digit
ssd_blank  in  NUM_DIGITS  1 = digit dark
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  cathodes, active-low; seg[6:0] = {Ca,Cb,Cc,Cd,Ce,Cf,Cg}
dp  out  1  decimal-point cathode, active-low

Behaviour:
Reset (Reset = 0, asynchronous):
- btn_level = 0, btn_pulse = 0, tick = 0, tick_cnt = 0.
- an = all 1, seg = 7'b1111111, dp = 1.
- All internal counters and synchroniser flops = 0; scan digit index = 0.
- Reset asserted mid-operation aborts everything immediately.

Buttons (per channel, channels independent):
- btn_raw passes through a 2-flop synchroniser to give s.
- If s == btn_level: debounce counter = 0.
- Otherwise the counter increments each cycle. On the cycle it equals DEB_CYCLES-1:
  - btn_level <= s and the counter clears.
  - btn_pulse <= 1 if s is 1; otherwise btn_pulse <= 0.
- btn_pulse is 0 on every other cycle.
- Latency from a clean raw edge to btn_level/btn_pulse: 2 + DEB_CYCLES cycles.
- Any bounce back to the current level restarts the count. A falling edge produces no pulse.

Tick timer:
- tick_clr has priority: prescaler = 0, tick_cnt = 0, tick = 0 on the next edge, regardless of tick_en.
- When tick_en = 1 and tick_clr = 0, the prescaler increments. When it reaches TICK_CYCLES-1 on an edge:
  - the prescaler wraps to 0;
  - tick = 1 for exactly one cycle;
  - tick_cnt increments, wrapping 2^TICK_W-1 -> 0.
- When tick_en = 0: the prescaler holds (pause, no loss of elapsed time) and tick = 0.
- First tick after a clear with tick_en held high is registered at the end of enabled cycle TICK_CYCLES.

Seven-segment scanner:
- A scan counter counts 0..SCAN_CYCLES-1. On wrap, the digit index advances by 1 modulo NUM_DIGITS (0, 1, ..., NUM_DIGITS-1, 0).
- an, seg and dp are registered and update on the same edge, so there is no ghosting.
- For the current digit k:
  - an[k] = 0 and all other anodes = 1.
  - seg = hex decode of nibble k.
  - dp = ~ssd_dp[k].
- If ssd_blank[k] = 1: an = all 1, seg = 7'b1111111, dp = 1.
- Inputs are sampled every cycle, so a data change is visible on the next edge.

Hex decode, active-low, {Ca..Cg}:
0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.

Counter widths are $clog2 of the respective cycle parameter; there is no overflow beyond the terminal count.

Decomposition:
- Package fpsr_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_BLANK = 7'b1111111;
  - default cycle constants for a 100 MHz clock (DEB_10MS, TICK_5S, SCAN_1KHZ).
- Sub-module fpsr_debounce handles one channel: synchroniser, counter, level and pulse, parameter DEB_CYCLES. It is instantiated NUM_BTN times in a generate loop.
- The timer and scanner are written inline.

Test Plan:
All scenarios use DEB_CYCLES=4, TICK_CYCLES=5, TICK_W=2, NUM_DIGITS=4, SCAN_CYCLES=3.
- btn_raw[0] rises and is held -> btn_pulse[0] = 1 for exactly one cycle, 6 cycles after the rise; btn_level[0] = 1 thereafter; other channels stay 0.
- btn_raw[1] high for 3 cycles, then low -> btn_level[1] and btn_pulse[1] stay 0. Release after an accepted press -> btn_level drops 6 cycles later with no pulse.
- tick_en = 1 for 12 cycles -> tick pulses after cycles 5 and 10, tick_cnt = 2. Drop tick_en for 7 cycles, then re-enable -> next tick after 3 more enabled cycles.
- Clear behaviour -> 4 ticks return tick_cnt to 0 (wrap). tick_clr together with tick_en on a terminal-count cycle -> tick = 0, tick_cnt = 0.
- Scanner with ssd_data = 16'h1208, ssd_blank = 4'b0100, ssd_dp = 4'b0001 -> each step lasts 3 cycles, repeating:
  - an = 1110: seg = 0000000, dp = 0
  - an = 1101: seg = 0000001, dp = 1
  - an = 1111: seg = 1111111, dp = 1
  - an = 0111: seg = 1001111, dp = 1
- Reset driven low mid-debounce and mid-scan -> all outputs take their reset values immediately, without waiting for a clock edge. After release, the scan restarts at digit 0 and any button press needs a full 6 cycles.
